seq_detect_1011: RTL and testbench

- Serial-stream consumer that sits directly downstream of the D flip-flop stage.
- Its din input is driven by the flop's registered Q output, one bit per clk.
- Implements a Moore FSM that recognises the bit pattern 1011, MSB first, in the serial stream.
- Flags each match with a one-cycle detect pulse and keeps a saturating count of matches for status readout.

---
 rtl/seq_detect_1011.sv | 69 ++++++
 tb/tb_seq_detect_1011.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_1011.sv
// Moore FSM that detects the serial pattern 1011 (MSB first) on din.
// Flags each match with detect (state S4) and keeps a saturating match count.
module seq_detect_1011 #(
    parameter int OVERLAP = 1,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               din,
    input  logic               clr,
    output logic               detect,
    output logic [COUNT_W-1:0] count,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_detect;
    logic [COUNT_W-1:0] r_count;
    state_t             w_next;
    logic               w_hit;

    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = din ? S1 : S0;
            S1:      w_next = din ? S1 : S2;
            S2:      w_next = din ? S3 : S0;
            S3:      w_next = din ? S4 : S2;
            // After a match, the trailing "10" may seed the next pattern only when overlapping
            S4:      w_next = din ? S1 : ((OVERLAP != 0) ? S2 : S0);
            default: w_next = S0;
        endcase
    end

    assign w_hit = en && (w_next == S4);

    // detect is registered alongside state so it always equals (state == S4)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S0;
            r_detect <= 1'b0;
            r_count  <= '0;
        end else begin
            if (en) begin
                r_state  <= w_next;
                r_detect <= (w_next == S4);
            end
            if (clr) begin
                r_count <= '0;
            end else if (w_hit && (r_count != '1)) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    assign detect = r_detect;
    assign count  = r_count;
    assign state  = r_state;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed bench for seq_detect_1011: overlapping, non-overlapping and 2-bit
// saturating instances share one stimulus stream; each task checks its own instance.
module tb_seq_detect_1011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;

    logic       ov1_detect, ov0_detect, sat_detect;
    logic [7:0] ov1_count, ov0_count;
    logic [1:0] sat_count;
    logic [2:0] ov1_state, ov0_state, sat_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_1011 #(.OVERLAP(1), .COUNT_W(8)) u_ov1 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .detect(ov1_detect), .count(ov1_count), .state(ov1_state)
    );

    seq_detect_1011 #(.OVERLAP(0), .COUNT_W(8)) u_ov0 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .detect(ov0_detect), .count(ov0_count), .state(ov0_state)
    );

    seq_detect_1011 #(.OVERLAP(1), .COUNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .detect(sat_detect), .count(sat_count), .state(sat_state)
    );

    task automatic step(input logic d, input logic e, input logic c);
        @(negedge clk);
        din = d;
        en  = e;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        din = 1'b0;
        clr = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (ov1_state !== 3'd0 || ov1_detect !== 1'b0 || ov1_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_init: state=%0d detect=%b count=%0d, want 0/0/0",
                     ov1_state, ov1_detect, ov1_count);
        end
        // five overlapping matches, then 1,0,1 to park in S3 with count=5
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        for (int unsigned k = 0; k < 4; k++) begin
            step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        end
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
        total++;
        if (ov1_state !== 3'd3 || ov1_count !== 8'd5) begin
            bad++;
            $display("FAIL reset_prep: state=%0d count=%0d, want 3/5", ov1_state, ov1_count);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (ov1_state !== 3'd0 || ov1_detect !== 1'b0 || ov1_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_async: state=%0d detect=%b count=%0d, want 0/0/0",
                     ov1_state, ov1_detect, ov1_count);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 1, 0);
        total++;
        if (ov1_state !== 3'd1 || ov1_detect !== 1'b0) begin
            bad++;
            $display("FAIL reset_discard: state=%0d detect=%b, want 1/0", ov1_state, ov1_detect);
        end
    endtask

    task automatic test_overlap();
        logic       s  [7] = '{1, 0, 1, 1, 0, 1, 1};
        logic [2:0] es [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd4};
        logic       ed [7] = '{0, 0, 0, 1, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(s[i], 1, 0);
            total++;
            if (ov1_state !== es[i] || ov1_detect !== ed[i]) begin
                bad++;
                $display("FAIL overlap_edge%0d: state=%0d detect=%b, want %0d/%b",
                         i + 1, ov1_state, ov1_detect, es[i], ed[i]);
            end
        end
        total++;
        if (ov1_count !== 8'd2) begin
            bad++;
            $display("FAIL overlap_count: got %0d want 2", ov1_count);
        end
    endtask

    task automatic test_no_overlap();
        logic       s  [7] = '{1, 0, 1, 1, 0, 1, 1};
        logic [2:0] es [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1};
        logic       ed [7] = '{0, 0, 0, 1, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(s[i], 1, 0);
            total++;
            if (ov0_state !== es[i] || ov0_detect !== ed[i]) begin
                bad++;
                $display("FAIL nooverlap_edge%0d: state=%0d detect=%b, want %0d/%b",
                         i + 1, ov0_state, ov0_detect, es[i], ed[i]);
            end
        end
        total++;
        if (ov0_count !== 8'd1) begin
            bad++;
            $display("FAIL nooverlap_count: got %0d want 1", ov0_count);
        end
    endtask

    task automatic test_enable();
        do_reset();
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0);
            total++;
            if (ov1_state !== 3'd3 || ov1_detect !== 1'b0 || ov1_count !== 8'd0) begin
                bad++;
                $display("FAIL enable_hold%0d: state=%0d detect=%b count=%0d, want 3/0/0",
                         i, ov1_state, ov1_detect, ov1_count);
            end
        end
        step(1, 1, 0);
        total++;
        if (ov1_state !== 3'd4 || ov1_detect !== 1'b1 || ov1_count !== 8'd1) begin
            bad++;
            $display("FAIL enable_match: state=%0d detect=%b count=%0d, want 4/1/1",
                     ov1_state, ov1_detect, ov1_count);
        end
        step(0, 0, 0);
        total++;
        if (ov1_state !== 3'd4 || ov1_detect !== 1'b1) begin
            bad++;
            $display("FAIL enable_s4_hold: state=%0d detect=%b, want 4/1", ov1_state, ov1_detect);
        end
    endtask

    task automatic test_saturate();
        logic [15:0] s = 16'b1011011011011011;
        logic [1:0]  ec [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
        logic        ed [16] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(s[15 - i], 1, 0);
            total++;
            if (sat_count !== ec[i] || sat_detect !== ed[i]) begin
                bad++;
                $display("FAIL saturate_edge%0d: count=%0d detect=%b, want %0d/%b",
                         i + 1, sat_count, sat_detect, ec[i], ed[i]);
            end
        end
    endtask

    task automatic test_clr_match();
        do_reset();
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        step(0, 1, 0); step(1, 1, 0);
        total++;
        if (ov1_state !== 3'd3 || ov1_count !== 8'd2) begin
            bad++;
            $display("FAIL clr_prep: state=%0d count=%0d, want 3/2", ov1_state, ov1_count);
        end
        step(1, 1, 1);
        total++;
        if (ov1_state !== 3'd4 || ov1_detect !== 1'b1 || ov1_count !== 8'd0) begin
            bad++;
            $display("FAIL clr_with_match: state=%0d detect=%b count=%0d, want 4/1/0",
                     ov1_state, ov1_detect, ov1_count);
        end
        step(0, 1, 0); step(1, 1, 0); step(1, 1, 0);
        total++;
        if (ov1_detect !== 1'b1 || ov1_count !== 8'd1) begin
            bad++;
            $display("FAIL clr_next_match: detect=%b count=%0d, want 1/1", ov1_detect, ov1_count);
        end
        step(0, 0, 1);
        total++;
        if (ov1_count !== 8'd0 || ov1_state !== 3'd4) begin
            bad++;
            $display("FAIL clr_no_enable: count=%0d state=%0d, want 0/4", ov1_count, ov1_state);
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_enable();
        test_saturate();
        test_clr_match();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
